// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data with data priority and fetch starvation limit
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem
);
    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        if_ready_q, if_ready_d, d_ready_q, d_ready_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic        if_elig, d_elig, pick_d;
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    // a requester in its ready cycle has just been served and cannot win again
    assign if_elig = if_req & ~if_ready_q;
    assign d_elig  = d_req & ~d_ready_q;
    assign pick_d  = d_elig & ~(if_elig & (starve_q == LIM));
    // arbitration in IDLE, completion on mem_ack in FETCH/DATA
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d     = DATA;
                    mem_we_d    = d_rw;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wmask_d = d_rw ? d_wmask : 4'h0;
                    starve_d    = !if_req ? 4'h0 : (starve_q >= LIM ? LIM : starve_q + 4'h1);
                end else if (if_elig) begin
                    state_d     = FETCH;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wmask_d = 4'h0;
                    starve_d    = 4'h0;
                end else if (!if_req) begin
                    starve_d = 4'h0;
                end
            end
            default: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    if (state_q == FETCH) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = mem_we_q ? d_rdata_q : mem_rdata;
                    end
                end
            end
        endcase
    end
    // state and output registers; reset abandons any outstanding transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= 4'h0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wmask_q <= 4'h0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end
    assign mem_req   = state_q != IDLE;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = d_req & ~d_ready_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported unified instruction/data memory between the fetch stage and the memory stage of the pipelined core. Each access is sequenced as a registered request/acknowledge transaction toward memory, and the result is returned to the winning requester. The block also drives the stall signals that freeze the pipeline while a stage waits. Data accesses have priority over fetches, with a starvation limiter that guarantees forward progress for fetch.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch is waiting; the next grant goes to fetch. Range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request; held until `if_ready`.
- `if_addr` in 32: fetch address; stable while `if_req`.
- `if_rdata` out 32: fetched word; valid when `if_ready`.
- `if_ready` out 1: one-cycle completion pulse for fetch.
- `d_req` in 1: data request from the memory stage; held until `d_ready`.
- `d_rw` in 1: 0 = read (load), 1 = write (store); matches control-unit `mem_rw`.
- `d_addr` in 32: data address (ALU output).
- `d_wdata` in 32: store data.
- `d_wmask` in 4: byte enables for the store.
- `d_rdata` out 32: load data; valid when `d_ready`.
- `d_ready` out 1: one-cycle completion pulse for data.
- `mem_req` out 1: memory request; held until `mem_ack`.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_wmask` out 4: memory byte mask; 0 on reads.
- `mem_rdata` in 32: memory read data; valid with `mem_ack`.
- `mem_ack` in 1: memory completion; may arrive in the same cycle as `mem_req` or any later cycle.
- `stall_if` out 1: `if_req & ~if_ready` (combinational).
- `stall_mem` out 1: `d_req & ~d_ready` (combinational).

## Operation
- FSM states: IDLE, FETCH, DATA.
- **Eligibility.** A requester is eligible in a cycle when its `req` is 1 and its `ready` is 0 in that cycle. The `ready` cycle consumes the request; re-arbitration for that requester starts the following cycle.
- **IDLE arbitration:**
  - If data is eligible and not (fetch is eligible and `starve_cnt == STARVE_LIMIT`): go to DATA.
  - Otherwise, if fetch is eligible: go to FETCH.
  - Otherwise: stay in IDLE.
- **Latching on grant.** The grant edge registers `mem_addr`, `mem_we`, `mem_wdata` and `mem_wmask` from the winner. For fetch: `mem_we` = 0 and mask = 0. For a data read: mask = 0.
- **FETCH / DATA states.** `mem_req` = 1 and memory outputs are held stable. On `mem_ack` = 1:
  - Return to IDLE.
  - Next cycle, pulse the winner's `ready` for exactly one cycle.
  - For a read, register `mem_rdata` into `if_rdata` or `d_rdata`.
  - A write leaves `d_rdata` unchanged.
- **`starve_cnt`** (4 bits):
  - Increments on each DATA grant made while `if_req` = 1.
  - Clears on each FETCH grant, and whenever `if_req` = 0 in IDLE.
  - Saturates at `STARVE_LIMIT`.
- `mem_ack` while in IDLE is ignored.
- **Reset.** Reset mid-transaction returns to IDLE immediately and abandons the outstanding transaction; no `ready` is produced for it.
- **Reset values:**
  - State = IDLE; `starve_cnt` = 0.
  - `mem_req`, `mem_we`, `if_ready`, `d_ready` = 0.
  - `mem_addr`, `mem_wdata`, `mem_wmask`, `if_rdata`, `d_rdata` = 0.
  - `stall_*` follow their combinational definitions.

## Timing
- **Minimum latency**, request eligible at cycle N:
  - Grant at edge N→N+1.
  - `mem_req` = 1 in N+1.
  - `mem_ack` in N+1 gives `ready` in N+2.
- Each extra wait cycle of `mem_ack` adds one cycle.
- **Throughput:** one transaction per 2 cycles minimum per port sequence. The `ready` cycle is IDLE and can grant the other requester. The same requester can be granted again at the earliest in the cycle after its `ready`.
- **Simultaneous eligible requests in IDLE:** data wins unless the starvation condition holds.
- `mem_*` outputs only change on grant edges or on reset.

## Test plan
- **Single fetch:**
  - Stimulus: `if_req` = 1, `if_addr` = 0x100, `mem_ack` same cycle with `mem_rdata` = 0x00500093.
  - Required: `mem_req` in cycle 1; `if_ready` = 1 and `if_rdata` = 0x00500093 in cycle 2; `stall_if` = 1 in cycles 0–1 only.
- **Store with wait states:**
  - Stimulus: `d_req` = 1, `d_rw` = 1, addr 0x2000, wdata 0xDEADBEEF, mask 0x3; `mem_ack` 3 cycles after `mem_req` rises.
  - Required: `mem_we` = 1, `mem_wmask` = 0x3 held 4 cycles; `d_ready` pulses once; `d_rdata` unchanged.
- **Collision:**
  - Stimulus: `if_req` and `d_req` (read) both asserted in cycle 0, zero-wait memory.
  - Required: data transaction first (`d_ready` in cycle 2), fetch granted in cycle 2 (`if_ready` in cycle 4).
- **Starvation:**
  - Stimulus: `STARVE_LIMIT` = 2; `if_req` held; `d_req` re-asserted every eligible cycle.
  - Required: grant order DATA, DATA, FETCH, DATA, DATA, FETCH.
- **Reset mid-transaction:**
  - Stimulus: `rst` during DATA with no `mem_ack`, then `mem_ack` = 1 after reset.
  - Required: `mem_req` = 0 next cycle, no `d_ready`, late `mem_ack` ignored, all outputs at reset values.
